nk_board_game: RTL and testbench

NK_BOARD_GAME -- requirements
Module: nk_board_game

---
 rtl/nk_board_game.sv | 208 ++++++++++++++++++++
 tb/tb_nk_board_game.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nk_board_game.sv
// N x N board, K-in-a-row game engine: accepts moves, places stones and scans four lines per move.
// Optional undo of the last placed stone is enabled by defining NK_BOARD_GAME_UNDO_EN.
module nk_board_game #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         x_in,
  input  logic [3:0]         y_in,
  input  logic               make_move,
`ifdef NK_BOARD_GAME_UNDO_EN
  input  logic               undo,
`endif
  output logic               move_ready,
  output logic               move_ack,
  output logic [1:0]         move_err,
  output logic [1:0]         winner,
  output logic               tie,
  output logic               turn,
  output logic [6:0]         move_count,
  output logic [2*N*N-1:0]   board
);

  localparam int         CELLS  = N * N;
  localparam logic [3:0] N4     = 4'(N);
  localparam logic [6:0] CELLS7 = 7'(CELLS);

  // Handshake: a move is taken on a rising edge where move_ready=1 and make_move=1;
  // it is answered one cycle later by either a move_ack pulse or a nonzero move_err pulse.
  typedef enum logic [1:0] {IDLE, PLACE, CHECK, DONE} state_t;

  state_t             state, next_state;
  logic [2*CELLS-1:0] board_q;
  logic [3:0]         cur_r, cur_c;
  logic [1:0]         dir_q;
  logic               in_range;
  logic [1:0]         req_cell;
  logic [1:0]         sym;
  logic               win_hit;
  int                 run_len;
  int                 dr, dc, rr, cc;
  logic               fwd_go, bwd_go;
`ifdef NK_BOARD_GAME_UNDO_EN
  logic               rec_valid;
  logic [3:0]         rec_r, rec_c;
`endif

  function automatic int lsb_of(input int r, input int c);
    return 2 * (CELLS - 1 - (r * N + c));
  endfunction

  function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int r, input int c);
    return b[lsb_of(r, c) +: 2];
  endfunction

  function automatic logic on_board(input int r, input int c);
    return (r >= 0) && (r < N) && (c >= 0) && (c < N);
  endfunction

  assign in_range = (x_in < N4) && (y_in < N4);
  assign sym      = turn ? 2'b10 : 2'b01;

  always_comb begin
    req_cell = 2'b00;
    if (in_range) req_cell = cell_at(board_q, int'(x_in), int'(y_in));
  end

  // Run length through the last placed cell along the direction selected by dir_q;
  // each sense stops at the first foreign cell or the board edge.
  always_comb begin
    dr      = 0;
    dc      = 1;
    rr      = 0;
    cc      = 0;
    run_len = 1;
    fwd_go  = 1'b1;
    bwd_go  = 1'b1;
    case (dir_q)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    for (int i = 1; i < N; i++) begin
      rr = int'(cur_r) + i * dr;
      cc = int'(cur_c) + i * dc;
      if (fwd_go && on_board(rr, cc)) begin
        if (cell_at(board_q, rr, cc) == sym) run_len = run_len + 1;
        else fwd_go = 1'b0;
      end else begin
        fwd_go = 1'b0;
      end
      rr = int'(cur_r) - i * dr;
      cc = int'(cur_c) - i * dc;
      if (bwd_go && on_board(rr, cc)) begin
        if (cell_at(board_q, rr, cc) == sym) run_len = run_len + 1;
        else bwd_go = 1'b0;
      end else begin
        bwd_go = 1'b0;
      end
    end
  end

  assign win_hit = (state == CHECK) && (run_len >= K);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (make_move && in_range && (req_cell == 2'b00)) next_state = PLACE;
      PLACE: next_state = CHECK;
      CHECK: begin
        if (win_hit)                next_state = DONE;
        else if (dir_q == 2'd3)     next_state = (move_count == CELLS7) ? DONE : IDLE;
      end
      DONE:  next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    move_ready = (state == IDLE);
    board      = board_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_q    <= '0;
      cur_r      <= 4'd0;
      cur_c      <= 4'd0;
      dir_q      <= 2'd0;
      winner     <= 2'b00;
      tie        <= 1'b0;
      turn       <= 1'b0;
      move_count <= 7'd0;
      move_ack   <= 1'b0;
      move_err   <= 2'b00;
`ifdef NK_BOARD_GAME_UNDO_EN
      rec_valid  <= 1'b0;
      rec_r      <= 4'd0;
      rec_c      <= 4'd0;
`endif
    end else begin
      move_ack <= 1'b0;
      move_err <= 2'b00;
      case (state)
        IDLE: begin
          if (make_move) begin
            if (!in_range)                move_err <= 2'b01;
            else if (req_cell != 2'b00)   move_err <= 2'b10;
            else begin
              cur_r    <= x_in;
              cur_c    <= y_in;
              move_ack <= 1'b1;
            end
          end
`ifdef NK_BOARD_GAME_UNDO_EN
          else if (undo) begin
            if (rec_valid) begin
              board_q[lsb_of(int'(rec_r), int'(rec_c)) +: 2] <= 2'b00;
              move_count <= move_count - 7'd1;
              turn       <= ~turn;
              rec_valid  <= 1'b0;
              move_ack   <= 1'b1;
            end else begin
              move_err <= 2'b10;
            end
          end
`endif
        end
        PLACE: begin
          board_q[lsb_of(int'(cur_r), int'(cur_c)) +: 2] <= sym;
          move_count <= move_count + 7'd1;
          dir_q      <= 2'd0;
`ifdef NK_BOARD_GAME_UNDO_EN
          rec_valid  <= 1'b1;
          rec_r      <= cur_r;
          rec_c      <= cur_c;
`endif
        end
        CHECK: begin
          // The mover keeps the turn on a win or a full board; turn only passes on a quiet move.
          if (win_hit) begin
            winner <= sym;
          end else if (dir_q == 2'd3) begin
            if (move_count == CELLS7) tie <= 1'b1;
            else                      turn <= ~turn;
          end else begin
            dir_q <= dir_q + 2'd1;
          end
        end
        DONE: begin
          if (make_move) move_err <= 2'b11;
`ifdef NK_BOARD_GAME_UNDO_EN
          else if (undo) move_err <= 2'b11;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nk_board_game.sv
// Bench for nk_board_game: a 3x3/K=3 instance and a 5x5/K=4 instance driven from a move table,
// plus short hand-written sequences for held requests, mid-check reset and undo.
module tb_nk_board_game;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  x3, y3, x5, y5;
  logic        mm3, mm5, undo3, undo5;
  logic        rdy3, ack3, tie3, turn3;
  logic [1:0]  err3, win3;
  logic [6:0]  cnt3;
  logic [17:0] brd3;
  logic        rdy5, ack5, tie5, turn5;
  logic [1:0]  err5, win5;
  logic [6:0]  cnt5;
  logic [49:0] brd5;

  nk_board_game #(.N(3), .K(3)) dut (
    .clk(clk), .rst(rst), .x_in(x3), .y_in(y3), .make_move(mm3),
`ifdef NK_BOARD_GAME_UNDO_EN
    .undo(undo3),
`endif
    .move_ready(rdy3), .move_ack(ack3), .move_err(err3), .winner(win3),
    .tie(tie3), .turn(turn3), .move_count(cnt3), .board(brd3)
  );

  nk_board_game #(.N(5), .K(4)) dut5 (
    .clk(clk), .rst(rst), .x_in(x5), .y_in(y5), .make_move(mm5),
`ifdef NK_BOARD_GAME_UNDO_EN
    .undo(undo5),
`endif
    .move_ready(rdy5), .move_ack(ack5), .move_err(err5), .winner(win5),
    .tie(tie5), .turn(turn5), .move_count(cnt5), .board(brd5)
  );

  typedef struct {
    bit          rst_before;
    bit          five;
    logic [3:0]  x, y;
    logic [1:0]  err;
    logic        ack;
    logic [1:0]  win;
    logic        tie;
    logic        turn;
    logic [6:0]  cnt;
    bit          chk_brd;
    logic [17:0] brd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit rb, input bit five, input int x, input int y,
                              input logic [1:0] err, input logic ack, input logic [1:0] win,
                              input logic tie, input logic turn, input int cnt,
                              input bit chk, input logic [17:0] brd);
    vec_t v;
    v.rst_before = rb;  v.five = five;  v.x = 4'(x);  v.y = 4'(y);
    v.err = err;  v.ack = ack;  v.win = win;  v.tie = tie;  v.turn = turn;
    v.cnt = 7'(cnt);  v.chk_brd = chk;  v.brd = brd;
    vecs.push_back(v);
  endfunction

  function automatic bit settled(input bit five);
    if (five) return rdy5 || (win5 != 2'b00) || tie5;
    return rdy3 || (win3 != 2'b00) || tie3;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One request pulse, then wait until idle again or the game result shows (6 cycles max).
  task automatic request(input bit five, input logic [3:0] x, input logic [3:0] y,
                         output logic [1:0] err, output logic ack, output bit timed_out);
    int cyc;
    @(negedge clk);
    if (five) begin x5 = x; y5 = y; mm5 = 1'b1; end
    else      begin x3 = x; y3 = y; mm3 = 1'b1; end
    @(negedge clk);
    mm3 = 1'b0;
    mm5 = 1'b0;
    err = five ? err5 : err3;
    ack = five ? ack5 : ack3;
    cyc = 1;
    while (!settled(five) && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    timed_out = !settled(five);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] err;
    logic       ack;
    bit         to;
    int         ack_seen, err_seen, cyc;
    int         pre_r[4];
    int         pre_c[4];

    rst = 1'b1;
    x3 = '0; y3 = '0; x5 = '0; y5 = '0;
    mm3 = 1'b0; mm5 = 1'b0; undo3 = 1'b0; undo5 = 1'b0;

    // Horizontal win for X.
    add(1, 0, 0, 0, 2'b00, 1, 2'b00, 0, 1, 1, 1, 18'b01_00_00_00_00_00_00_00_00);
    add(0, 0, 1, 0, 2'b00, 1, 2'b00, 0, 0, 2, 1, 18'b01_00_00_10_00_00_00_00_00);
    add(0, 0, 0, 1, 2'b00, 1, 2'b00, 0, 1, 3, 1, 18'b01_01_00_10_00_00_00_00_00);
    add(0, 0, 1, 1, 2'b00, 1, 2'b00, 0, 0, 4, 1, 18'b01_01_00_10_10_00_00_00_00);
    add(0, 0, 0, 2, 2'b00, 1, 2'b01, 0, 0, 5, 1, 18'b01_01_01_10_10_00_00_00_00);
    add(0, 0, 1, 2, 2'b11, 0, 2'b01, 0, 0, 5, 1, 18'b01_01_01_10_10_00_00_00_00);
    // Occupied and out-of-range requests.
    add(1, 0, 1, 1, 2'b00, 1, 2'b00, 0, 1, 1, 1, 18'b00_00_00_00_01_00_00_00_00);
    add(0, 0, 1, 1, 2'b10, 0, 2'b00, 0, 1, 1, 1, 18'b00_00_00_00_01_00_00_00_00);
    add(0, 0, 3, 0, 2'b01, 0, 2'b00, 0, 1, 1, 1, 18'b00_00_00_00_01_00_00_00_00);
    add(0, 0, 0, 3, 2'b01, 0, 2'b00, 0, 1, 1, 1, 18'b00_00_00_00_01_00_00_00_00);
    // Draw, then a request in DONE.
    add(1, 0, 0, 0, 2'b00, 1, 2'b00, 0, 1, 1, 1, 18'b01_00_00_00_00_00_00_00_00);
    add(0, 0, 0, 1, 2'b00, 1, 2'b00, 0, 0, 2, 1, 18'b01_10_00_00_00_00_00_00_00);
    add(0, 0, 0, 2, 2'b00, 1, 2'b00, 0, 1, 3, 1, 18'b01_10_01_00_00_00_00_00_00);
    add(0, 0, 1, 1, 2'b00, 1, 2'b00, 0, 0, 4, 1, 18'b01_10_01_00_10_00_00_00_00);
    add(0, 0, 1, 0, 2'b00, 1, 2'b00, 0, 1, 5, 1, 18'b01_10_01_01_10_00_00_00_00);
    add(0, 0, 2, 0, 2'b00, 1, 2'b00, 0, 0, 6, 1, 18'b01_10_01_01_10_00_10_00_00);
    add(0, 0, 1, 2, 2'b00, 1, 2'b00, 0, 1, 7, 1, 18'b01_10_01_01_10_01_10_00_00);
    add(0, 0, 2, 2, 2'b00, 1, 2'b00, 0, 0, 8, 1, 18'b01_10_01_01_10_01_10_00_10);
    add(0, 0, 2, 1, 2'b00, 1, 2'b00, 1, 0, 9, 1, 18'b01_10_01_01_10_01_10_01_10);
    add(0, 0, 0, 0, 2'b11, 0, 2'b00, 1, 0, 9, 1, 18'b01_10_01_01_10_01_10_01_10);
    // Diagonal win on the ninth move: winner reported, no tie.
    add(1, 0, 0, 0, 2'b00, 1, 2'b00, 0, 1, 1, 1, 18'b01_00_00_00_00_00_00_00_00);
    add(0, 0, 0, 1, 2'b00, 1, 2'b00, 0, 0, 2, 1, 18'b01_10_00_00_00_00_00_00_00);
    add(0, 0, 0, 2, 2'b00, 1, 2'b00, 0, 1, 3, 1, 18'b01_10_01_00_00_00_00_00_00);
    add(0, 0, 1, 0, 2'b00, 1, 2'b00, 0, 0, 4, 1, 18'b01_10_01_10_00_00_00_00_00);
    add(0, 0, 1, 1, 2'b00, 1, 2'b00, 0, 1, 5, 1, 18'b01_10_01_10_01_00_00_00_00);
    add(0, 0, 1, 2, 2'b00, 1, 2'b00, 0, 0, 6, 1, 18'b01_10_01_10_01_10_00_00_00);
    add(0, 0, 2, 1, 2'b00, 1, 2'b00, 0, 1, 7, 1, 18'b01_10_01_10_01_10_00_01_00);
    add(0, 0, 2, 0, 2'b00, 1, 2'b00, 0, 0, 8, 1, 18'b01_10_01_10_01_10_10_01_00);
    add(0, 0, 2, 2, 2'b00, 1, 2'b01, 0, 0, 9, 1, 18'b01_10_01_10_01_10_10_01_01);
    // Vertical win for O.
    add(1, 0, 0, 0, 2'b00, 1, 2'b00, 0, 1, 1, 1, 18'b01_00_00_00_00_00_00_00_00);
    add(0, 0, 0, 1, 2'b00, 1, 2'b00, 0, 0, 2, 1, 18'b01_10_00_00_00_00_00_00_00);
    add(0, 0, 1, 0, 2'b00, 1, 2'b00, 0, 1, 3, 1, 18'b01_10_00_01_00_00_00_00_00);
    add(0, 0, 1, 1, 2'b00, 1, 2'b00, 0, 0, 4, 1, 18'b01_10_00_01_10_00_00_00_00);
    add(0, 0, 2, 2, 2'b00, 1, 2'b00, 0, 1, 5, 1, 18'b01_10_00_01_10_00_00_00_01);
    add(0, 0, 2, 1, 2'b00, 1, 2'b10, 0, 1, 6, 1, 18'b01_10_00_01_10_00_00_10_01);
    // 5x5, K=4: anti-diagonal win for X on move 7.
    add(1, 1, 0, 3, 2'b00, 1, 2'b00, 0, 1, 1, 0, '0);
    add(0, 1, 4, 4, 2'b00, 1, 2'b00, 0, 0, 2, 0, '0);
    add(0, 1, 1, 2, 2'b00, 1, 2'b00, 0, 1, 3, 0, '0);
    add(0, 1, 4, 3, 2'b00, 1, 2'b00, 0, 0, 4, 0, '0);
    add(0, 1, 2, 1, 2'b00, 1, 2'b00, 0, 1, 5, 0, '0);
    add(0, 1, 4, 1, 2'b00, 1, 2'b00, 0, 0, 6, 0, '0);
    add(0, 1, 3, 0, 2'b00, 1, 2'b01, 0, 0, 7, 0, '0);
    // 5x5: X at (0,3)(0,4)(1,0)(1,1) is adjacent in memory but must not count across the edge.
    add(1, 1, 0, 3, 2'b00, 1, 2'b00, 0, 1, 1, 0, '0);
    add(0, 1, 2, 0, 2'b00, 1, 2'b00, 0, 0, 2, 0, '0);
    add(0, 1, 0, 4, 2'b00, 1, 2'b00, 0, 1, 3, 0, '0);
    add(0, 1, 2, 2, 2'b00, 1, 2'b00, 0, 0, 4, 0, '0);
    add(0, 1, 1, 0, 2'b00, 1, 2'b00, 0, 1, 5, 0, '0);
    add(0, 1, 3, 3, 2'b00, 1, 2'b00, 0, 0, 6, 0, '0);
    add(0, 1, 1, 1, 2'b00, 1, 2'b00, 0, 1, 7, 0, '0);

    // Reset state.
    #12;
    check("rst board", brd3, 18'd0);
    check("rst board5", brd5, 50'd0);
    check("rst ready", rdy3, 1'b1);
    check("rst winner", win3, 2'b00);
    check("rst tie", tie3, 1'b0);
    check("rst turn", turn3, 1'b0);
    check("rst count", cnt3, 7'd0);
    check("rst ack", ack3, 1'b0);
    check("rst err", err3, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      request(vecs[i].five, vecs[i].x, vecs[i].y, err, ack, to);
      check($sformatf("v%0d timeout", i), to, 1'b0);
      check($sformatf("v%0d err", i), err, vecs[i].err);
      check($sformatf("v%0d ack", i), ack, vecs[i].ack);
      check($sformatf("v%0d winner", i), vecs[i].five ? win5 : win3, vecs[i].win);
      check($sformatf("v%0d tie", i), vecs[i].five ? tie5 : tie3, vecs[i].tie);
      check($sformatf("v%0d turn", i), vecs[i].five ? turn5 : turn3, vecs[i].turn);
      check($sformatf("v%0d count", i), vecs[i].five ? cnt5 : cnt3, vecs[i].cnt);
      if (vecs[i].chk_brd) check($sformatf("v%0d board", i), brd3, vecs[i].brd);
    end

    // make_move held high while the engine is busy: only the first request counts.
    do_reset();
    @(negedge clk);
    x3 = 4'd0; y3 = 4'd0; mm3 = 1'b1;
    ack_seen = 0;
    err_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x3 = 4'd2; y3 = 4'd2;
      if (ack3) ack_seen++;
      if (err3 != 2'b00) err_seen++;
    end
    mm3 = 1'b0;
    cyc = 0;
    while (!rdy3 && cyc < 6) begin
      @(negedge clk);
      cyc++;
      if (ack3) ack_seen++;
      if (err3 != 2'b00) err_seen++;
    end
    check("held timeout", rdy3, 1'b1);
    check("held acks", ack_seen, 1);
    check("held errs", err_seen, 0);
    check("held count", cnt3, 7'd1);
    check("held board", brd3, 18'b01_00_00_00_00_00_00_00_00);
    check("held turn", turn3, 1'b1);

    // Reset while the fifth (winning) move is being checked.
    do_reset();
    pre_r = '{0, 1, 0, 1};
    pre_c = '{0, 0, 1, 1};
    for (int i = 0; i < 4; i++) request(1'b0, 4'(pre_r[i]), 4'(pre_c[i]), err, ack, to);
    check("midrst pre count", cnt3, 7'd4);
    @(negedge clk);
    x3 = 4'd0; y3 = 4'd2; mm3 = 1'b1;
    @(negedge clk);
    mm3 = 1'b0;
    @(negedge clk);
    check("midrst placed count", cnt3, 7'd5);
    rst = 1'b1;
    #1;
    check("midrst board", brd3, 18'd0);
    check("midrst count", cnt3, 7'd0);
    check("midrst ready", rdy3, 1'b1);
    check("midrst winner", win3, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    request(1'b0, 4'd1, 4'd1, err, ack, to);
    check("postrst ack", ack, 1'b1);
    check("postrst count", cnt3, 7'd1);
    check("postrst winner", win3, 2'b00);

`ifdef NK_BOARD_GAME_UNDO_EN
    do_reset();
    request(1'b0, 4'd0, 4'd0, err, ack, to);
    check("undo place ack", ack, 1'b1);
    @(negedge clk);
    undo3 = 1'b1;
    @(negedge clk);
    undo3 = 1'b0;
    check("undo ack", ack3, 1'b1);
    check("undo board", brd3, 18'd0);
    check("undo turn", turn3, 1'b0);
    check("undo count", cnt3, 7'd0);
    @(negedge clk);
    undo3 = 1'b1;
    @(negedge clk);
    undo3 = 1'b0;
    check("undo2 err", err3, 2'b10);
    check("undo2 ack", ack3, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
